// File: rtl/psram_req_sequencer_pkg.sv
// Shared definitions for the PSRAM request sequencer: FSM encoding,
// 23-bit word-address mask, wait-counter width and timing defaults.
package psram_req_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ISSUE,
    S_WR_WAIT,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RD_HOLD
  } state_t;

  localparam int ADDR_W = 24;
  localparam int WORD_W = 16;
  localparam int CNT_W  = 16;

  // The PSRAM array is 8M words, so bit 23 of any address is always zero.
  localparam logic [ADDR_W-1:0] ADDR_MASK = 24'h7F_FFFF;

  localparam int WR_CYCLES_DEF  = 16;
  localparam int RD_TIMEOUT_DEF = 64;

  function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] a);
    return (a + 24'd1) & ADDR_MASK;
  endfunction

endpackage

// File: rtl/psram_wait_counter.sv
// Down-counter shared by the write-settle wait and the read timeout.
// o_done is high in the last enabled cycle of the loaded count.
module psram_wait_counter
  import psram_req_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  input  logic             i_enable,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (i_enable && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_done = i_enable && (r_cnt == CNT_W'(1));

endmodule

// File: rtl/psram_req_sequencer.sv
// Serialises a write word stream and read bursts into single-word
// request pulses for a PSRAM controller; writes win ties in IDLE.
module psram_req_sequencer
  import psram_req_sequencer_pkg::*;
#(
  parameter int WR_CYCLES  = WR_CYCLES_DEF,
  parameter int RD_TIMEOUT = RD_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] wr_base,
  input  logic              wr_base_load,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_cmd_valid,
  output logic              rd_cmd_ready,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [15:0]       rd_len,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_done,
  output logic              rd_timeout_err,
  output logic              ctrl_read,
  output logic              ctrl_write,
  output logic [ADDR_W-1:0] ctrl_address,
  output logic [WORD_W-1:0] ctrl_data,
  input  logic [WORD_W-1:0] ctrl_data_out,
  input  logic              ctrl_read_data
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [15:0]       r_rd_rem;
  logic              r_wr_ready;
  logic              r_rd_cmd_ready;
  logic              r_rd_valid;
  logic [WORD_W-1:0] r_rd_data;
  logic              r_rd_done;
  logic              r_timeout_err;
  logic              r_ctrl_read;
  logic              r_ctrl_write;
  logic [ADDR_W-1:0] r_ctrl_address;
  logic [WORD_W-1:0] r_ctrl_data;

  logic              w_cnt_load;
  logic [CNT_W-1:0]  w_cnt_val;
  logic              w_cnt_en;
  logic              w_cnt_done;

  // The counter is armed in the issue state and runs in the matching wait state.
  assign w_cnt_load = (r_state == S_WR_ISSUE) || (r_state == S_RD_ISSUE);
  assign w_cnt_val  = (r_state == S_WR_ISSUE) ? CNT_W'(WR_CYCLES) : CNT_W'(RD_TIMEOUT);
  assign w_cnt_en   = (r_state == S_WR_WAIT) || (r_state == S_RD_WAIT);

  psram_wait_counter u_wait (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_cnt_load),
    .i_value  (w_cnt_val),
    .i_enable (w_cnt_en),
    .o_done   (w_cnt_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_wr_ptr       <= '0;
      r_rd_addr      <= '0;
      r_rd_rem       <= '0;
      r_wr_ready     <= 1'b0;
      r_rd_cmd_ready <= 1'b0;
      r_rd_valid     <= 1'b0;
      r_rd_data      <= '0;
      r_rd_done      <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_ctrl_read    <= 1'b0;
      r_ctrl_write   <= 1'b0;
      r_ctrl_address <= '0;
      r_ctrl_data    <= '0;
    end else begin
      r_wr_ready     <= 1'b0;
      r_rd_cmd_ready <= 1'b0;
      r_rd_done      <= 1'b0;
      r_ctrl_read    <= 1'b0;
      r_ctrl_write   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (wr_base_load) begin
            r_wr_ptr <= wr_base & ADDR_MASK;
          end else if (wr_valid) begin
            r_wr_ready     <= 1'b1;
            r_ctrl_data    <= wr_data;
            r_ctrl_address <= r_wr_ptr;
            r_state        <= S_WR_ISSUE;
          end else if (rd_cmd_valid && !r_rd_cmd_ready) begin
            // The ready guard stops a held command from being taken twice.
            r_rd_cmd_ready <= 1'b1;
            r_rd_addr      <= rd_base & ADDR_MASK;
            r_rd_rem       <= rd_len;
            if (rd_len == 16'd0) r_rd_done <= 1'b1;
            else                 r_state   <= S_RD_ISSUE;
          end
        end
        S_WR_ISSUE: begin
          r_ctrl_write <= 1'b1;
          r_state      <= S_WR_WAIT;
        end
        S_WR_WAIT: begin
          if (w_cnt_done) begin
            r_wr_ptr <= addr_next(r_wr_ptr);
            r_state  <= S_IDLE;
          end
        end
        S_RD_ISSUE: begin
          r_ctrl_read    <= 1'b1;
          r_ctrl_address <= r_rd_addr;
          r_state        <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (ctrl_read_data) begin
            r_rd_data  <= ctrl_data_out;
            r_rd_valid <= 1'b1;
            r_state    <= S_RD_HOLD;
          end else if (w_cnt_done) begin
            r_timeout_err <= 1'b1;
            r_state       <= S_IDLE;
          end
        end
        S_RD_HOLD: begin
          if (rd_ready) begin
            r_rd_valid <= 1'b0;
            r_rd_addr  <= addr_next(r_rd_addr);
            r_rd_rem   <= r_rd_rem - 16'd1;
            if (r_rd_rem == 16'd1) begin
              r_rd_done <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_state <= S_RD_ISSUE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wr_ready       = r_wr_ready;
  assign rd_cmd_ready   = r_rd_cmd_ready;
  assign rd_valid       = r_rd_valid;
  assign rd_data        = r_rd_data;
  assign rd_done        = r_rd_done;
  assign rd_timeout_err = r_timeout_err;
  assign ctrl_read      = r_ctrl_read;
  assign ctrl_write     = r_ctrl_write;
  assign ctrl_address   = r_ctrl_address;
  assign ctrl_data      = r_ctrl_data;

endmodule

// File: tb/tb_psram_req_sequencer.sv
// Directed bench for psram_req_sequencer with a fixed-latency controller
// model, a table of single-word writes and hand-written read sequences.
module tb_psram_req_sequencer;

  localparam int WRC     = 16;
  localparam int RTO     = 64;
  localparam int MDL_LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] wr_base;
  logic        wr_base_load;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic        rd_cmd_valid;
  logic        rd_cmd_ready;
  logic [23:0] rd_base;
  logic [15:0] rd_len;
  logic        rd_valid;
  logic        rd_ready;
  logic [15:0] rd_data;
  logic        rd_done;
  logic        rd_timeout_err;
  logic        ctrl_read;
  logic        ctrl_write;
  logic [23:0] ctrl_address;
  logic [15:0] ctrl_data;
  logic [15:0] ctrl_data_out = 16'h0000;
  logic        ctrl_read_data = 1'b0;

  psram_req_sequencer #(.WR_CYCLES(WRC), .RD_TIMEOUT(RTO)) dut (
    .clk            (clk),
    .reset          (reset),
    .wr_base        (wr_base),
    .wr_base_load   (wr_base_load),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_data        (wr_data),
    .rd_cmd_valid   (rd_cmd_valid),
    .rd_cmd_ready   (rd_cmd_ready),
    .rd_base        (rd_base),
    .rd_len         (rd_len),
    .rd_valid       (rd_valid),
    .rd_ready       (rd_ready),
    .rd_data        (rd_data),
    .rd_done        (rd_done),
    .rd_timeout_err (rd_timeout_err),
    .ctrl_read      (ctrl_read),
    .ctrl_write     (ctrl_write),
    .ctrl_address   (ctrl_address),
    .ctrl_data      (ctrl_data),
    .ctrl_data_out  (ctrl_data_out),
    .ctrl_read_data (ctrl_read_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Bus monitor
  int          cyc = 0;
  logic [23:0] wq_addr[$];
  logic [15:0] wq_data[$];
  int          wq_cyc[$];
  logic [23:0] rq_addr[$];
  int          done_cnt = 0;

  always @(posedge clk) begin
    cyc++;
    if (ctrl_write === 1'b1) begin
      wq_addr.push_back(ctrl_address);
      wq_data.push_back(ctrl_data);
      wq_cyc.push_back(cyc);
    end
    if (ctrl_read === 1'b1) rq_addr.push_back(ctrl_address);
    if (rd_done === 1'b1) done_cnt++;
  end

  // Controller model: strobes the next queued word MDL_LAT cycles after ctrl_read
  logic [15:0] mdl_q[$];
  bit          model_en = 1'b1;
  int          lat_cnt = 0;

  always @(negedge clk) begin
    ctrl_read_data = 1'b0;
    if (reset === 1'b1) begin
      lat_cnt = 0;
    end else if (ctrl_read === 1'b1 && model_en) begin
      lat_cnt = MDL_LAT;
    end else if (lat_cnt > 0) begin
      lat_cnt--;
      if (lat_cnt == 0) begin
        ctrl_read_data = 1'b1;
        ctrl_data_out  = (mdl_q.size() > 0) ? mdl_q.pop_front() : 16'hDEAD;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_sig(input int sel, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      case (sel)
        0:       hit = (wr_ready === 1'b1);
        1:       hit = (rd_cmd_ready === 1'b1);
        2:       hit = (rd_valid === 1'b1);
        default: hit = 1'b0;
      endcase
    end
    if (!hit) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got 0 after 200 cycles, expected 1", name);
    end
  endtask

  task automatic clear_mon();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
    rq_addr.delete();
    done_cnt = 0;
  endtask

  task automatic base_load(input logic [23:0] b);
    wr_base      = b;
    wr_base_load = 1'b1;
    @(negedge clk);
    wr_base_load = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] d);
    wr_data  = d;
    wr_valid = 1'b1;
    wait_sig(0, "wr_ready");
    wr_valid = 1'b0;
  endtask

  task automatic rd_cmd(input logic [23:0] b, input logic [15:0] len);
    rd_base      = b;
    rd_len       = len;
    rd_cmd_valid = 1'b1;
    wait_sig(1, "rd_cmd_ready");
    rd_cmd_valid = 1'b0;
  endtask

  task automatic accept(output logic [15:0] d);
    wait_sig(2, "rd_valid");
    d        = rd_data;
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_wr_ready"},     wr_ready, 0);
    chk({tag, "_rd_cmd_ready"}, rd_cmd_ready, 0);
    chk({tag, "_rd_valid"},     rd_valid, 0);
    chk({tag, "_rd_data"},      rd_data, 0);
    chk({tag, "_rd_done"},      rd_done, 0);
    chk({tag, "_timeout_err"},  rd_timeout_err, 0);
    chk({tag, "_ctrl_read"},    ctrl_read, 0);
    chk({tag, "_ctrl_write"},   ctrl_write, 0);
    chk({tag, "_ctrl_address"}, ctrl_address, 0);
    chk({tag, "_ctrl_data"},    ctrl_data, 0);
  endtask

  typedef struct {
    bit          load;
    logic [23:0] base;
    logic [15:0] data;
    logic [23:0] exp_addr;
  } wvec_t;

  wvec_t tbl[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] d;
    bit          stable;
    int          ready_cyc;

    tbl[0] = '{1'b1, 24'h000100, 16'hBEEF, 24'h000100};
    tbl[1] = '{1'b0, 24'h000000, 16'h1234, 24'h000101};
    tbl[2] = '{1'b1, 24'hFFFFFF, 16'hA5A5, 24'h7FFFFF};
    tbl[3] = '{1'b0, 24'h000000, 16'h0F0F, 24'h000000};
    tbl[4] = '{1'b1, 24'h400000, 16'hFFFF, 24'h400000};

    reset = 1'b1;
    wr_base = '0; wr_base_load = 1'b0; wr_valid = 1'b0; wr_data = '0;
    rd_cmd_valid = 1'b0; rd_base = '0; rd_len = '0; rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("por");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single-word writes from the table
    for (int i = 0; i < 5; i++) begin
      if (tbl[i].load) base_load(tbl[i].base);
      clear_mon();
      do_write(tbl[i].data);
      repeat (WRC + 4) @(negedge clk);
      chk($sformatf("tbl%0d_nwrites", i), wq_addr.size(), 1);
      if (wq_addr.size() > 0) begin
        chk($sformatf("tbl%0d_addr", i), wq_addr[0], tbl[i].exp_addr);
        chk($sformatf("tbl%0d_data", i), wq_data[0], tbl[i].data);
      end
    end

    // Three-word stream and pulse spacing
    base_load(24'h000010);
    clear_mon();
    do_write(16'h1111);
    do_write(16'h2222);
    do_write(16'h3333);
    repeat (WRC + 4) @(negedge clk);
    chk("stream_nwrites", wq_addr.size(), 3);
    if (wq_addr.size() == 3) begin
      chk("stream_a0", wq_addr[0], 24'h10);
      chk("stream_a1", wq_addr[1], 24'h11);
      chk("stream_a2", wq_addr[2], 24'h12);
      chk("stream_d2", wq_data[2], 16'h3333);
      chk("stream_gap01", (wq_cyc[1] - wq_cyc[0]) >= WRC + 2, 1);
      chk("stream_gap12", (wq_cyc[2] - wq_cyc[1]) >= WRC + 2, 1);
    end

    // Read burst with a 5-cycle stall on the first word
    clear_mon();
    mdl_q = {16'hAAAA, 16'h5555};
    rd_cmd(24'h000020, 16'd2);
    wait_sig(2, "rd_valid_w0");
    chk("burst_w0", rd_data, 16'hAAAA);
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (rd_valid !== 1'b1 || rd_data !== 16'hAAAA) stable = 1'b0;
    end
    chk("burst_stall_stable", stable, 1);
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    chk("burst_valid_drop", rd_valid, 0);
    chk("burst_no_early_done", done_cnt, 0);
    accept(d);
    chk("burst_w1", d, 16'h5555);
    repeat (2) @(negedge clk);
    chk("burst_done", done_cnt, 1);
    chk("burst_nreads", rq_addr.size(), 2);
    if (rq_addr.size() == 2) begin
      chk("burst_ra0", rq_addr[0], 24'h20);
      chk("burst_ra1", rq_addr[1], 24'h21);
    end

    // Write and read command raised together: write goes first
    repeat (3) @(negedge clk);
    base_load(24'h000050);
    clear_mon();
    mdl_q = {16'hC3C3};
    wr_data = 16'h7777; wr_valid = 1'b1;
    rd_base = 24'h000030; rd_len = 16'd1; rd_cmd_valid = 1'b1;
    wait_sig(0, "race_wr_ready");
    chk("race_no_rdcmd_yet", rd_cmd_ready, 0);
    wr_valid = 1'b0;
    wait_sig(1, "race_rd_cmd_ready");
    ready_cyc = cyc;
    rd_cmd_valid = 1'b0;
    chk("race_wr_first", wq_addr.size(), 1);
    if (wq_addr.size() == 1) begin
      chk("race_wr_addr", wq_addr[0], 24'h50);
      chk("race_rd_after_wr", (ready_cyc - wq_cyc[0]) >= WRC, 1);
    end
    accept(d);
    chk("race_rd_data", d, 16'hC3C3);
    repeat (2) @(negedge clk);
    chk("race_done", done_cnt, 1);
    if (rq_addr.size() > 0) chk("race_rd_addr", rq_addr[0], 24'h30);
    else chk("race_nreads", rq_addr.size(), 1);

    // Burst across the top of the 23-bit address space
    clear_mon();
    mdl_q = {16'h0001, 16'h0002};
    rd_cmd(24'h7FFFFF, 16'd2);
    accept(d);
    chk("wrap_w0", d, 16'h0001);
    accept(d);
    chk("wrap_w1", d, 16'h0002);
    repeat (2) @(negedge clk);
    chk("wrap_nreads", rq_addr.size(), 2);
    if (rq_addr.size() == 2) begin
      chk("wrap_ra0", rq_addr[0], 24'h7FFFFF);
      chk("wrap_ra1", rq_addr[1], 24'h000000);
    end
    chk("wrap_done", done_cnt, 1);

    // Controller never answers: timeout
    clear_mon();
    model_en = 1'b0;
    rd_cmd(24'h000040, 16'd1);
    repeat (40) @(negedge clk);
    chk("to_not_yet", rd_timeout_err, 0);
    repeat (30) @(negedge clk);
    chk("to_set", rd_timeout_err, 1);
    chk("to_no_valid", rd_valid, 0);
    chk("to_no_done", done_cnt, 0);
    chk("to_nreads", rq_addr.size(), 1);
    model_en = 1'b1;
    base_load(24'h000200);
    do_write(16'h4242);
    repeat (WRC + 4) @(negedge clk);
    chk("to_idle_write", wq_addr.size(), 1);
    if (wq_addr.size() == 1) chk("to_idle_addr", wq_addr[0], 24'h200);
    chk("to_sticky", rd_timeout_err, 1);

    // Reset while holding a read word
    clear_mon();
    mdl_q = {16'h9999, 16'h8888};
    rd_cmd(24'h000060, 16'd2);
    wait_sig(2, "hold_rd_valid");
    chk("hold_data", rd_data, 16'h9999);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset("midrst");
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst_no_done", done_cnt, 0);
    chk("midrst_nreads", rq_addr.size(), 1);

    // Zero-length read command
    clear_mon();
    rd_cmd(24'h000070, 16'd0);
    repeat (3) @(negedge clk);
    chk("len0_done", done_cnt, 1);
    chk("len0_no_read", rq_addr.size(), 0);
    chk("len0_no_valid", rd_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
